instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 114 +++++++++++
 tb/tb_instr_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Program-buffer instruction sequencer: replays up to 16 {instruction, hold}
// entries to the control unit, each issued hold+1 times, with stall/abort.
module instr_sequencer #(
  parameter int IW    = 88,
  parameter int HW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_wr_en,
  input  logic [AW-1:0] prog_wr_addr,
  input  logic [IW-1:0] prog_wr_instr,
  input  logic [HW-1:0] prog_wr_hold,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          stall,
  input  logic          abort,
  output logic [IW-1:0] instruction,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          wr_err
);

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [HW-1:0] hold;
  } entry_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  entry_t [DEPTH-1:0] mem;
  state_t             state;
  logic [HW-1:0]      rem;
  logic [AW-1:0]      last_pc;

  logic [AW:0]   eff_len, len_m1;
  logic [AW-1:0] pc_nx;
  logic [HW-1:0] start_hold;

  assign eff_len = (prog_len > 5'd16) ? 5'd16 : prog_len;
  assign len_m1  = eff_len - 5'd1;
  assign pc_nx   = pc + 1'b1;
  // A write to entry 0 in the start cycle must seed rem with the new hold.
  assign start_hold = (prog_wr_en && prog_wr_addr == '0) ? prog_wr_hold : mem[0].hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem         <= '0;
      state       <= IDLE;
      rem         <= '0;
      last_pc     <= '0;
      instruction <= '0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_err <= 1'b0;
      if (prog_wr_en) begin
        if (state == IDLE) mem[prog_wr_addr] <= {prog_wr_instr, prog_wr_hold};
        else               wr_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          instruction <= '0;
          pc          <= '0;
          if (start) begin
            if (eff_len == '0) begin
              done <= 1'b1;
            end else begin
              state   <= RUN;
              busy    <= 1'b1;
              rem     <= start_hold;
              last_pc <= len_m1[AW-1:0];
            end
          end
        end
        RUN: begin
          if (abort) begin
            state       <= IDLE;
            instruction <= '0;
            pc          <= '0;
            busy        <= 1'b0;
          end else if (stall) begin
            instruction <= '0;
          end else begin
            instruction <= mem[pc].instr;
            if (rem != '0) begin
              rem <= rem - 1'b1;
            end else if (pc != last_pc) begin
              pc  <= pc_nx;
              rem <= mem[pc_nx].hold;
            end else begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // Last issue stays visible here; completion only if not aborted.
          state       <= IDLE;
          instruction <= '0;
          pc          <= '0;
          busy        <= 1'b0;
          done        <= !abort;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scenarios plus random traffic, checked every cycle against a
// queue-based issue model of the sequencer.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, prog_wr_en, start, stall, abort;
  logic [3:0]  prog_wr_addr;
  logic [87:0] prog_wr_instr;
  logic [7:0]  prog_wr_hold;
  logic [4:0]  prog_len;
  logic [87:0] instruction;
  logic [3:0]  pc;
  logic        busy, done, wr_err;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr),
    .prog_wr_instr(prog_wr_instr), .prog_wr_hold(prog_wr_hold), .start(start),
    .prog_len(prog_len), .stall(stall), .abort(abort), .instruction(instruction),
    .pc(pc), .busy(busy), .done(done), .wr_err(wr_err)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model: the program is flattened into a queue of entry indices,
  // one element per issue; each unstalled run cycle consumes one.
  logic [87:0] m_instr [16];
  int          m_hold  [16];
  int          q [$];
  int          m_mode;  // 0 idle, 1 run, 2 flush
  logic [87:0] e_instr;
  int          e_pc;
  logic        e_busy, e_done, e_werr;

  logic [87:0] A, B, C, D;

  task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int len, e;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin m_instr[i] = '0; m_hold[i] = 0; end
      q.delete(); m_mode = 0;
      e_instr = '0; e_pc = 0; e_busy = 0; e_done = 0; e_werr = 0;
      return;
    end
    e_done = 0; e_werr = 0;
    if (prog_wr_en) begin
      if (m_mode == 0) begin
        m_instr[prog_wr_addr] = prog_wr_instr;
        m_hold[prog_wr_addr]  = int'(prog_wr_hold);
      end else e_werr = 1;
    end
    case (m_mode)
      0: begin
        e_instr = '0; e_pc = 0;
        if (start) begin
          len = (prog_len > 16) ? 16 : int'(prog_len);
          if (len == 0) e_done = 1;
          else begin
            q.delete();
            for (int i = 0; i < len; i++)
              for (int k = 0; k <= m_hold[i]; k++) q.push_back(i);
            m_mode = 1; e_busy = 1;
          end
        end
      end
      1: begin
        if (abort) begin
          m_mode = 0; q.delete(); e_instr = '0; e_pc = 0; e_busy = 0;
        end else if (stall) begin
          e_instr = '0;
        end else begin
          e = q.pop_front();
          e_instr = m_instr[e];
          if (q.size() == 0) m_mode = 2;
          else e_pc = q[0];
        end
      end
      default: begin
        e_done = !abort;
        m_mode = 0; e_instr = '0; e_pc = 0; e_busy = 0;
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("instruction", instruction, e_instr);
    chk("pc", 88'(pc), 88'(e_pc[3:0]));
    chk("busy", 88'(busy), 88'(e_busy));
    chk("done", 88'(done), 88'(e_done));
    chk("wr_err", 88'(wr_err), 88'(e_werr));
  endtask

  task automatic wr(input int addr, input logic [87:0] ins, input int hold);
    prog_wr_en = 1; prog_wr_addr = addr[3:0]; prog_wr_instr = ins; prog_wr_hold = hold[7:0];
    tick();
    prog_wr_en = 0;
  endtask

  task automatic go(input int len);
    prog_len = len[4:0]; start = 1;
    tick();
    start = 0;
  endtask

  task automatic run_out();
    for (int i = 0; i < 2000 && (busy || e_busy); i++) tick();
    chk("run_terminates", 88'(busy), 88'(0));
  endtask

  function automatic logic [87:0] rnd88();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[87:0];
  endfunction

  initial begin
    logic [87:0] seq [6];
    rst = 1; prog_wr_en = 0; prog_wr_addr = '0; prog_wr_instr = '0; prog_wr_hold = '0;
    start = 0; prog_len = '0; stall = 0; abort = 0; m_mode = 0;
    A = rnd88(); B = rnd88(); C = rnd88(); D = rnd88();
    tick();
    tick();
    rst = 0;
    chk("reset_instr", instruction, 88'(0));
    chk("reset_busy", 88'(busy), 88'(0));

    // Basic program A(0) B(2) C(0), L=3
    wr(0, A, 0); wr(1, B, 2); wr(2, C, 0);
    go(3);
    chk("s1_busy_c1", 88'(busy), 88'(1));
    seq[0] = A; seq[1] = B; seq[2] = B; seq[3] = B; seq[4] = C; seq[5] = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("s1_seq", instruction, seq[c]);
    end
    chk("s1_done_c7", 88'(done), 88'(1));

    // Same program, all holds 0, stall in cycle 3
    wr(1, B, 0);
    go(3);
    tick(); chk("s2_c2", instruction, A);
    tick(); chk("s2_c3", instruction, B);
    stall = 1; tick(); stall = 0;
    chk("s2_c4_nop", instruction, 88'(0));
    tick(); chk("s2_c5", instruction, C);
    tick(); chk("s2_done_c6", 88'(done), 88'(1));

    // Abort in cycle 3
    wr(1, B, 2);
    go(3); tick(); tick();
    abort = 1; tick(); abort = 0;
    chk("s3_instr", instruction, 88'(0));
    chk("s3_busy", 88'(busy), 88'(0));
    chk("s3_pc", 88'(pc), 88'(0));
    for (int i = 0; i < 4; i++) tick();

    // Zero-length program
    go(0);
    chk("s4_done", 88'(done), 88'(1));
    chk("s4_busy", 88'(busy), 88'(0));
    tick();

    // Write during run is rejected
    go(3);
    prog_wr_en = 1; prog_wr_addr = 4'd1; prog_wr_instr = D; prog_wr_hold = 8'd0;
    tick(); prog_wr_en = 0;
    chk("s5_wr_err", 88'(wr_err), 88'(1));
    run_out();
    go(3); tick(); tick();
    chk("s5_old_entry", instruction, B);
    run_out();

    // Reset mid-run clears the buffer
    go(3); tick(); tick(); tick();
    rst = 1; tick(); rst = 0;
    chk("s6_instr", instruction, 88'(0));
    chk("s6_busy", 88'(busy), 88'(0));
    go(3); tick(); tick();
    chk("s6_nop", instruction, 88'(0));
    run_out();

    // Write + start in the same cycle, clamp of long programs
    prog_wr_en = 1; prog_wr_addr = 4'd0; prog_wr_instr = D; prog_wr_hold = 8'd1;
    go(20); prog_wr_en = 0;
    tick(); chk("s7_bypass", instruction, D);
    run_out();

    // Random traffic
    for (int it = 0; it < 3000; it++) begin
      rst = ($urandom % 250) == 0;
      prog_wr_en = ($urandom % 6) == 0;
      prog_wr_addr = 4'($urandom % 16);
      prog_wr_instr = ($urandom % 8 == 0) ? '0 : rnd88();
      prog_wr_hold = 8'(($urandom % 16 == 0) ? $urandom % 12 : $urandom % 3);
      start = ($urandom % 5) == 0;
      prog_len = 5'($urandom % 21);
      stall = ($urandom % 4) == 0;
      abort = ($urandom % 50) == 0;
      tick();
    end
    rst = 0; prog_wr_en = 0; start = 0; stall = 0; abort = 0;
    run_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
